// File: rtl/demux18_reg_pkg.sv
// Shared channel geometry and mode encodings for the demux write side and the
// 8:1 mux read side, so both agree on channel count and address width.
package demux18_reg_pkg;
    localparam int NUM_CH = 8;
    localparam int ADDR_W = 3;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [ADDR_W-1:0] ch);
        return NUM_CH'(1) << ch;
    endfunction
endpackage

// File: rtl/demux18_reg_if.sv
// Producer/consumer bundle of the registered 1-to-8 demultiplexer.
interface demux18_reg_if #(
    parameter int width = 8
);
    import demux18_reg_pkg::*;

    logic                CSn;
    logic                mode;
    logic [ADDR_W-1:0]   A;
    logic [width-1:0]    D;
    logic                D_valid;
    logic                D_ready;
    logic [width-1:0]    Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
    logic [NUM_CH-1:0]   Y_valid;
    logic [NUM_CH-1:0]   Y_ack;
    logic [ADDR_W-1:0]   scan_ptr;
    logic                all_full;

    modport master (
        output CSn, mode, A, D, D_valid, Y_ack,
        input  D_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid, scan_ptr, all_full
    );

    modport slave (
        input  CSn, mode, A, D, D_valid, Y_ack,
        output D_ready, Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7, Y_valid, scan_ptr, all_full
    );
endinterface

// File: rtl/demux18_reg_slot.sv
// One channel holding register with its valid flag; data survives an ack.
module demux_slot #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] D,
    input  logic             ack,
    output logic [width-1:0] Y,
    output logic             Y_valid
);
    // load is only ever asserted while the slot is empty, so set and clear never collide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y       <= '0;
            Y_valid <= 1'b0;
        end else begin
            if (load) begin
                Y <= D;
            end
            Y_valid <= load | (Y_valid & ~ack);
        end
    end
endmodule

// File: rtl/demux18_reg.sv
// Registered 1-to-8 demultiplexer: steers D to one channel slot by address or
// by an auto-scan pointer, with per-channel valid/ack handshakes.
module demux18_reg
    import demux18_reg_pkg::*;
#(
    parameter int width = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    demux18_reg_if.slave  bus
);
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] valid_next;
    logic [NUM_CH-1:0] load;
    logic [width-1:0]  y [NUM_CH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] tgt;
    logic              ready;
    logic              accept;
    logic              full;

    assign tgt    = (bus.mode == MODE_SCAN) ? ptr : bus.A;
    assign ready  = !bus.CSn && !valid[tgt];
    assign accept = bus.D_valid && ready;
    assign load   = accept ? ch_onehot(tgt) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign valid_next[gi] = load[gi] | (valid[gi] & ~bus.Y_ack[gi]);

            demux_slot #(
                .width(width)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load[gi]),
                .D       (bus.D),
                .ack     (bus.Y_ack[gi]),
                .Y       (y[gi]),
                .Y_valid (valid[gi])
            );
        end
    endgenerate

    // Pointer only moves on a real accept, so a stalled channel stalls the stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && bus.mode == MODE_SCAN) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else begin
            full <= &valid_next;
        end
    end

    assign bus.D_ready  = ready;
    assign bus.Y_valid  = valid;
    assign bus.scan_ptr = ptr;
    assign bus.all_full = full;
    assign bus.Y0       = y[0];
    assign bus.Y1       = y[1];
    assign bus.Y2       = y[2];
    assign bus.Y3       = y[3];
    assign bus.Y4       = y[4];
    assign bus.Y5       = y[5];
    assign bus.Y6       = y[6];
    assign bus.Y7       = y[7];
endmodule

// File: tb/tb_demux18_reg.sv
// Bench for demux18_reg: directed table, corner-case sequences and random
// traffic checked against a channel-array reference model.
module tb_demux18_reg;
    import demux18_reg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux18_reg_if #(.width(8)) bus();

    demux18_reg #(.width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] y_m [8];
    logic [7:0] v_m;
    logic [2:0] p_m;

    typedef struct {
        logic       csn;
        logic       mode;
        logic [2:0] a;
        logic [7:0] d;
        logic       dv;
        logic [7:0] ack;
        logic       exp_rdy;
        logic [7:0] exp_valid;
        logic [2:0] exp_ptr;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [63:0] dut_y();
        return {bus.Y7, bus.Y6, bus.Y5, bus.Y4, bus.Y3, bus.Y2, bus.Y1, bus.Y0};
    endfunction

    function automatic logic [63:0] mdl_y();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = y_m[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) y_m[i] = 8'h00;
        v_m = 8'h00;
        p_m = 3'd0;
    endtask

    task automatic drive(input logic csn, input logic mode, input logic [2:0] a,
                         input logic [7:0] d, input logic dv, input logic [7:0] ack);
        bus.CSn     = csn;
        bus.mode    = mode;
        bus.A       = a;
        bus.D       = d;
        bus.D_valid = dv;
        bus.Y_ack   = ack;
    endtask

    // One clock of traffic; starts and ends 1 time unit after a rising edge.
    task automatic step(input logic csn, input logic mode, input logic [2:0] a,
                        input logic [7:0] d, input logic dv, input logic [7:0] ack,
                        output logic dut_rdy);
        logic [2:0] tgt;
        logic       rdy_m;
        logic [7:0] nv;
        drive(csn, mode, a, d, dv, ack);
        #1;
        tgt     = mode ? p_m : a;
        rdy_m   = !csn && !v_m[tgt];
        dut_rdy = bus.D_ready;
        check("d_ready", 64'(dut_rdy), 64'(rdy_m));
        nv = v_m & ~ack;
        if (dv && rdy_m) begin
            y_m[tgt] = d;
            nv[tgt]  = 1'b1;
            if (mode) p_m = 3'((p_m + 1) % 8);
        end
        v_m = nv;
        @(posedge clk);
        #1;
        check("y_valid", 64'(bus.Y_valid), 64'(v_m));
        check("scan_ptr", 64'(bus.scan_ptr), 64'(p_m));
        check("all_full", 64'(bus.all_full), 64'(v_m == 8'hFF));
        check("y_data", dut_y(), mdl_y());
        $display("step csn=%b mode=%b a=%0d d=%h dv=%b ack=%h rdy=%b valid=%h ptr=%0d full=%b",
                 csn, mode, a, d, dv, ack, dut_rdy, bus.Y_valid, bus.scan_ptr, bus.all_full);
    endtask

    // Asserts reset away from any clock edge and checks it takes effect at once.
    task automatic do_reset();
        @(posedge clk);
        drive(1'b0, 1'($urandom), 3'($urandom), 8'($urandom), 1'b1, 8'($urandom));
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_y", dut_y(), 64'h0);
        check("rst_valid", 64'(bus.Y_valid), 64'h0);
        check("rst_ptr", 64'(bus.scan_ptr), 64'h0);
        check("rst_full", 64'(bus.all_full), 64'h0);
        model_reset();
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset valid=%h ptr=%0d", bus.Y_valid, bus.scan_ptr);
    endtask

    initial begin
        logic dr;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //            csn   mode  a     d      dv    ack    rdy   valid  ptr
        tbl[0] = '{1'b0, 1'b0, 3'd5, 8'hA5, 1'b1, 8'h00, 1'b1, 8'h20, 3'd0};
        tbl[1] = '{1'b0, 1'b0, 3'd5, 8'h3C, 1'b1, 8'h00, 1'b0, 8'h20, 3'd0};
        tbl[2] = '{1'b0, 1'b0, 3'd5, 8'h3C, 1'b1, 8'h20, 1'b0, 8'h00, 3'd0};
        tbl[3] = '{1'b0, 1'b0, 3'd5, 8'h3C, 1'b1, 8'h00, 1'b1, 8'h20, 3'd0};
        tbl[4] = '{1'b1, 1'b0, 3'd2, 8'h77, 1'b1, 8'h20, 1'b0, 8'h00, 3'd0};
        tbl[5] = '{1'b0, 1'b1, 3'd6, 8'h10, 1'b1, 8'h00, 1'b1, 8'h01, 3'd1};
        tbl[6] = '{1'b0, 1'b1, 3'd0, 8'h11, 1'b1, 8'h01, 1'b1, 8'h02, 3'd2};
        tbl[7] = '{1'b0, 1'b0, 3'd1, 8'h55, 1'b1, 8'h02, 1'b0, 8'h00, 3'd2};

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].csn, tbl[i].mode, tbl[i].a, tbl[i].d, tbl[i].dv, tbl[i].ack, dr);
            check($sformatf("tbl%0d_rdy", i), 64'(dr), 64'(tbl[i].exp_rdy));
            check($sformatf("tbl%0d_valid", i), 64'(bus.Y_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_ptr", i), 64'(bus.scan_ptr), 64'(tbl[i].exp_ptr));
        end
        check("tbl_y5", 64'(bus.Y5), 64'h3C);
        check("tbl_y2_untouched", 64'(bus.Y2), 64'h00);

        // Auto-scan wrap, each channel acked one cycle after its fill
        do_reset();
        for (int k = 0; k < 9; k++) begin
            check("wrap_ptr_seq", 64'(bus.scan_ptr), 64'(k % 8));
            step(1'b0, MODE_SCAN, 3'($urandom), 8'(8'h10 + k), 1'b1,
                 (k == 0) ? 8'h00 : 8'(8'h01 << ((k - 1) % 8)), dr);
        end
        check("wrap_ptr_end", 64'(bus.scan_ptr), 64'd1);
        check("wrap_y", dut_y(), 64'h17161514_13121118);

        // Fill every channel with no acks, then free channel 0
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, MODE_SCAN, 3'd0, 8'(8'h20 + k), 1'b1, 8'h00, dr);
        end
        check("full_flag", 64'(bus.all_full), 64'd1);
        check("full_ptr", 64'(bus.scan_ptr), 64'd0);
        step(1'b0, MODE_SCAN, 3'd0, 8'h99, 1'b1, 8'h00, dr);
        check("full_no_ready", 64'(dr), 64'd0);
        step(1'b0, MODE_SCAN, 3'd0, 8'h99, 1'b0, 8'h01, dr);
        drive(1'b0, MODE_SCAN, 3'd0, 8'h99, 1'b0, 8'h00);
        #1;
        check("full_ready_after_ack", 64'(bus.D_ready), 64'd1);
        check("full_flag_clear", 64'(bus.all_full), 64'd0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ack;
            ack = 8'($urandom) & 8'($urandom);
            step(($urandom_range(0, 7) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), ack, dr);
        end

        do_reset();
        check("final_valid", 64'(bus.Y_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/demux18_reg.md
Name: demux18_reg

Overview:
- Registered 1-to-8 demultiplexer with per-channel holding registers and valid/ack handshakes.
- One input word stream is steered to one of eight output channels, either by explicit address or by an auto-incrementing scan pointer.
- Sits upstream of an 8:1 channel-select mux and is its write-side counterpart: it fills the eight channel words, and the mux reads them back.
- Active-low chip select CSn gates the whole block.

Parameters:
- width, 8, data word width in bits for D and Y0..Y7.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- CSn  input  1  chip select, active low; when high the block accepts nothing and holds all state.
- mode  input  1  0 = addressed (target = A), 1 = auto-scan (target = scan pointer).
- A  input  3  channel address used when mode = 0.
- D  input  width  input data word.
- D_valid  input  1  producer has a word on D.
- D_ready  output  1  block can accept D this cycle (combinational).
- Y0..Y7  output  width each  channel holding registers.
- Y_valid  output  8  bit i high = Y<i> holds an unconsumed word.
- Y_ack  input  8  bit i high = consumer of channel i takes Y<i> this cycle.
- scan_ptr  output  3  current auto-scan pointer.
- all_full  output  1  high when all eight Y_valid bits are high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Y0..Y7 = 0, Y_valid = 8'h00, scan_ptr = 0, all_full = 0.
  - Holds while low; the first update comes on the first rising clk after release.
- Target channel: tgt = mode ? scan_ptr : A (combinational).
- D_ready = !CSn && !Y_valid[tgt]. This is combinational from current state only and is independent of Y_ack in the same cycle.
- Accept = D_valid && D_ready. On accept:
  - Y<tgt> <= D at the next edge.
  - Y_valid[tgt] <= 1 at the next edge.
  - Latency D -> Y<tgt>/Y_valid is 1 cycle.
- Auto-scan:
  - In mode = 1, scan_ptr increments on each accept and wraps 7 -> 0.
  - No accept means no increment. A stalled target blocks the whole stream; there is no skipping.
- In mode = 0, scan_ptr holds. Switching mode never resets scan_ptr.
- Ack:
  - Y_ack[i] && Y_valid[i] clears Y_valid[i] at the next edge.
  - Y<i> data is NOT cleared; it keeps its last value.
  - Y_ack[i] with Y_valid[i] = 0 is ignored.
- Same-channel accept and ack in one cycle cannot occur, because D_ready is low whenever the target is valid. The ack wins and the word is accepted in a later cycle at the earliest.
- Different channels: an accept on channel j and an ack on channel i in the same cycle both take effect.
- CSn high:
  - D_ready = 0, so no accepts and scan_ptr holds.
  - Acks still clear valids, so consumers can drain while deselected.
  - Y registers hold their values (no zeroing, unlike the mux read path).
- all_full = &Y_valid, registered together with Y_valid (same cycle alignment).
- A, mode, and D are don't-care when D_valid = 0 or CSn = 1.
- Reset mid-transfer: any pending word is lost and all valids drop immediately. No partial state survives.

Decomposition:
- Shared package/include:
  - NUM_CH = 8, ADDR_W = 3.
  - Mode encodings MODE_ADDR = 1'b0, MODE_SCAN = 1'b1.
  - Shared with the 8:1 mux so both sides agree on channel count and address width.
- Sub-module demux_slot (parameter width), instantiated 8 times:
  - Ports: clk, rst_n, load, D, ack, Y, Y_valid.
  - Holds one register plus its valid flag with set/clear logic.
- The top level holds the target decode, D_ready, scan_ptr counter and all_full.

Test Plan:
- Reset: drive garbage, pulse rst_n low mid-cycle -> Y0..Y7 = 0, Y_valid = 00, scan_ptr = 0 immediately, no clock needed.
- Addressed write: mode = 0, A = 5, D = 8'hA5, D_valid one cycle -> next cycle Y5 = A5, Y_valid = 8'h20, other Y unchanged.
- Backpressure: with Y_valid[5] = 1, A = 5, D = 8'h3C held valid -> D_ready = 0 and Y5 stays A5. Pulse Y_ack[5] -> Y_valid[5] clears at the next edge, then 3C is accepted the cycle after.
- Auto-scan wrap: mode = 1, stream 9 words 8'h10..8'h18 while acking each channel immediately after fill -> Y0..Y7 = 10..17 and Y0 = 18. scan_ptr sequence 0..7, 0, 1.
- Full: fill all 8 in scan mode with no acks -> all_full = 1 and D_ready = 0 for the 9th word. Ack channel 0 -> D_ready = 1 the next cycle (ptr = 0).
- CSn gating: CSn = 1, D_valid = 1, A = 2, D = 8'h77 -> D_ready = 0, no change. Concurrent Y_ack[5] still clears Y_valid[5], and scan_ptr is unchanged.
